// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target. Accepts one request,
// commits byte-masked writes at acceptance, waits LATENCY cycles, then
// presents a registered response held until the requester takes it.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Upper bound of the implemented range, one bit wider than the address so
  // DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // Configuration sanity checks, evaluated at elaboration.
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 0..15");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("mem_responder: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("mem_responder: DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Transaction seen when the response is being formed; with LATENCY=0 the
  // response is built on the acceptance edge, before addr_q/we_q are loaded.
  logic                enter_resp;
  logic                resp_we;
  logic [ADDR_W-1:0]   resp_addr;
  logic                mem_wr_en;

  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  // Next-state, handshake and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    resp_we     = we_q;
    resp_addr   = addr_q;
    mem_wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          req_ready_d = 1'b0;
          mem_wr_en   = req_we && in_range(req_addr);
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
            resp_we    = req_we;
            resp_addr  = req_addr;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range(resp_addr);
      if (!resp_we && in_range(resp_addr)) begin
        rsp_rdata_d = mem[resp_addr[IDX_W-1:0]];
      end else begin
        rsp_rdata_d = '0;
      end
    end
  end

  // Control and output registers; asynchronous reset abandons any transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM write port: byte-masked commit on the acceptance edge, never reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_wstrb[i]) begin
          mem[req_addr[IDX_W-1:0]][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
